fp_mac_add_status_pipe: RTL and testbench

//  Parametrised, flow-controlled successor to the MAC adder-status register stage.

---
 rtl/fp_mac_add_status_pipe.sv | 162 ++++++++++++++++
 tb/tb_fp_mac_add_status_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mac_add_status_pipe.sv
// Adder-status register stage between the mantissa adder and the normaliser.
// Masks overflow on effective subtraction, flags exact zeros, and buffers beats behind a 2-entry valid/ready skid.
module fp_mac_add_status_pipe #(
    parameter int MANT_W   = 24,
    parameter int EXP_W    = 8,
    parameter int CNT_W    = 16,
    parameter bit ZERO_POS = 1'b1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              clr_count,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] in_adder_out,
    input  logic              in_ov_sign,
    input  logic              in_adder_out_sign,
    input  logic              in_sign_in1,
    input  logic              in_sign_in2,
    input  logic [EXP_W-1:0]  in_current_ex,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] out_adder_out,
    output logic              out_ov_sign,
    output logic              out_adder_out_sign,
    output logic [EXP_W-1:0]  out_current_ex,
    output logic              out_eff_sub,
    output logic              out_zero,
    output logic [CNT_W-1:0]  ov_count
);

    typedef struct packed {
        logic [MANT_W-1:0] adder;
        logic              ov;
        logic              sign;
        logic [EXP_W-1:0]  ex;
        logic              eff_sub;
        logic              zero;
    } beat_t;

    beat_t            r_main;
    beat_t            r_skid;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_ov_count;

    beat_t w_beat;
    logic  w_eff_sub;
    logic  w_ov;
    logic  w_zero;
    logic  w_accept;
    logic  w_pop;
    logic  w_main_valid_nxt;
    logic  w_skid_valid_nxt;
    logic  w_load_main_from_in;
    logic  w_load_main_from_skid;
    logic  w_load_skid;
    logic  w_count_inc;

    // A carry-out on an effective subtraction is not a real overflow, so it is masked here.
    assign w_eff_sub = in_sign_in1 ^ in_sign_in2;
    assign w_ov      = w_eff_sub ? 1'b0 : in_ov_sign;
    assign w_zero    = (in_adder_out == '0) && !w_ov;

    always_comb begin
        w_beat.adder   = in_adder_out;
        w_beat.ov      = w_ov;
        w_beat.sign    = (ZERO_POS && w_zero) ? 1'b0 : in_adder_out_sign;
        w_beat.ex      = in_current_ex;
        w_beat.eff_sub = w_eff_sub;
        w_beat.zero    = w_zero;
    end

    assign w_accept = in_valid && r_in_ready;
    assign w_pop    = r_main_valid && out_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        w_main_valid_nxt      = r_main_valid;
        w_skid_valid_nxt      = r_skid_valid;
        w_load_main_from_in   = 1'b0;
        w_load_main_from_skid = 1'b0;
        w_load_skid           = 1'b0;
        if (flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid || w_pop) begin
            if (r_skid_valid) begin
                w_load_main_from_skid = 1'b1;
                w_main_valid_nxt      = 1'b1;
                w_load_skid           = w_accept;
                w_skid_valid_nxt      = w_accept;
            end else begin
                w_load_main_from_in = w_accept;
                w_main_valid_nxt    = w_accept;
            end
        end else if (w_accept) begin
            w_load_skid      = 1'b1;
            w_skid_valid_nxt = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    // NOTE: the data registers are reset as well because out_* must read zero straight out of reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main_from_skid) begin
                r_main <= r_skid;
            end else if (w_load_main_from_in) begin
                r_main <= w_beat;
            end
            if (w_load_skid) begin
                r_skid <= w_beat;
            end
        end
    end

    // Beats accepted during a flush are discarded, so they must not count either.
    assign w_count_inc = w_accept && w_ov && !flush && (r_ov_count != '1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ov_count <= '0;
        end else if (clr_count) begin
            r_ov_count <= '0;
        end else if (w_count_inc) begin
            r_ov_count <= r_ov_count + CNT_W'(1);
        end
    end

    assign in_ready           = r_in_ready;
    assign out_valid          = r_main_valid;
    assign out_adder_out      = r_main.adder;
    assign out_ov_sign        = r_main.ov;
    assign out_adder_out_sign = r_main.sign;
    assign out_current_ex     = r_main.ex;
    assign out_eff_sub        = r_main.eff_sub;
    assign out_zero           = r_main.zero;
    assign ov_count           = r_ov_count;

    a_skid_implies_main: assert property (@(posedge clock) disable iff (!resetn)
        r_skid_valid |-> r_main_valid);
    a_ready_tracks_skid: assert property (@(posedge clock) disable iff (!resetn)
        r_in_ready == !r_skid_valid);

endmodule

// File: tb/tb_fp_mac_add_status_pipe.sv
// Bench for fp_mac_add_status_pipe: directed vector table, hand-written flow-control sequences,
// and a randomized run against a 2-deep FIFO reference model. A CNT_W=2 instance shares all inputs.
module tb_fp_mac_add_status_pipe;

    logic        clock;
    logic        resetn;
    logic        flush;
    logic        clr_count;
    logic        in_valid;
    logic [23:0] in_adder_out;
    logic        in_ov_sign;
    logic        in_adder_out_sign;
    logic        in_sign_in1;
    logic        in_sign_in2;
    logic [7:0]  in_current_ex;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [23:0] out_adder_out;
    logic        out_ov_sign;
    logic        out_adder_out_sign;
    logic [7:0]  out_current_ex;
    logic        out_eff_sub;
    logic        out_zero;
    logic [15:0] ov_count;

    logic        c2_in_ready;
    logic        c2_out_valid;
    logic [23:0] c2_out_adder_out;
    logic        c2_out_ov_sign;
    logic        c2_out_adder_out_sign;
    logic [7:0]  c2_out_current_ex;
    logic        c2_out_eff_sub;
    logic        c2_out_zero;
    logic [1:0]  c2_ov_count;

    fp_mac_add_status_pipe dut (
        .clock(clock), .resetn(resetn), .flush(flush), .clr_count(clr_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_adder_out(in_adder_out),
        .in_ov_sign(in_ov_sign), .in_adder_out_sign(in_adder_out_sign),
        .in_sign_in1(in_sign_in1), .in_sign_in2(in_sign_in2), .in_current_ex(in_current_ex),
        .out_valid(out_valid), .out_ready(out_ready), .out_adder_out(out_adder_out),
        .out_ov_sign(out_ov_sign), .out_adder_out_sign(out_adder_out_sign),
        .out_current_ex(out_current_ex), .out_eff_sub(out_eff_sub), .out_zero(out_zero),
        .ov_count(ov_count)
    );

    fp_mac_add_status_pipe #(.CNT_W(2)) dut_c2 (
        .clock(clock), .resetn(resetn), .flush(flush), .clr_count(clr_count),
        .in_valid(in_valid), .in_ready(c2_in_ready), .in_adder_out(in_adder_out),
        .in_ov_sign(in_ov_sign), .in_adder_out_sign(in_adder_out_sign),
        .in_sign_in1(in_sign_in1), .in_sign_in2(in_sign_in2), .in_current_ex(in_current_ex),
        .out_valid(c2_out_valid), .out_ready(out_ready), .out_adder_out(c2_out_adder_out),
        .out_ov_sign(c2_out_ov_sign), .out_adder_out_sign(c2_out_adder_out_sign),
        .out_current_ex(c2_out_current_ex), .out_eff_sub(c2_out_eff_sub), .out_zero(c2_out_zero),
        .ov_count(c2_ov_count)
    );

    typedef struct {
        logic [23:0] adder;
        logic        ov;
        logic        sign;
        logic        s1;
        logic        s2;
        logic [7:0]  ex;
    } beat_in_t;

    typedef struct {
        logic [23:0] adder;
        logic        ov;
        logic        sign;
        logic [7:0]  ex;
        logic        eff;
        logic        zero;
    } beat_out_t;

    typedef struct {
        beat_in_t in;
        beat_out_t exp;
        int        cnt;
        int        cnt2;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    beat_out_t q[$];
    int        m_cnt  = 0;
    int        m_cnt2 = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic beat_in_t mk_in(logic [23:0] a, logic ov, logic sg, logic s1, logic s2,
                                       logic [7:0] ex);
        beat_in_t b;
        b.adder = a; b.ov = ov; b.sign = sg; b.s1 = s1; b.s2 = s2; b.ex = ex;
        return b;
    endfunction

    // Reference transform straight from the beat rules, with ZERO_POS=1.
    function automatic beat_out_t ref_beat(beat_in_t b);
        beat_out_t o;
        o.eff   = (b.s1 != b.s2);
        o.ov    = o.eff ? 1'b0 : b.ov;
        o.zero  = (b.adder == 24'd0) && !o.ov;
        o.sign  = o.zero ? 1'b0 : b.sign;
        o.adder = b.adder;
        o.ex    = b.ex;
        return o;
    endfunction

    function automatic vec_t mk_vec(beat_in_t b, logic eov, logic esg, logic eeff, logic ez,
                                    int c, int c2);
        vec_t v;
        v.in = b;
        v.exp.adder = b.adder; v.exp.ex = b.ex;
        v.exp.ov = eov; v.exp.sign = esg; v.exp.eff = eeff; v.exp.zero = ez;
        v.cnt = c; v.cnt2 = c2;
        return v;
    endfunction

    task automatic drive(input beat_in_t b, input logic v);
        in_valid          = v;
        in_adder_out      = b.adder;
        in_ov_sign        = b.ov;
        in_adder_out_sign = b.sign;
        in_sign_in1       = b.s1;
        in_sign_in2       = b.s2;
        in_current_ex     = b.ex;
    endtask

    task automatic check_out(input string tag, input beat_out_t e);
        check({tag, ".adder"}, 64'(out_adder_out), 64'(e.adder));
        check({tag, ".ov"}, 64'(out_ov_sign), 64'(e.ov));
        check({tag, ".sign"}, 64'(out_adder_out_sign), 64'(e.sign));
        check({tag, ".ex"}, 64'(out_current_ex), 64'(e.ex));
        check({tag, ".eff"}, 64'(out_eff_sub), 64'(e.eff));
        check({tag, ".zero"}, 64'(out_zero), 64'(e.zero));
    endtask

    // Reference: a 2-deep FIFO; ready whenever fewer than two beats are held.
    task automatic model_step(input logic v, input beat_in_t b, input logic ordy,
                              input logic fl, input logic clr);
        beat_out_t bo;
        logic acc;
        logic pop;
        bo  = ref_beat(b);
        acc = v && (q.size() < 2);
        pop = (q.size() > 0) && ordy;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(bo);
        end
        if (clr) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (acc && bo.ov && !fl) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    vec_t     vecs[8];
    beat_in_t idle;
    beat_in_t b;
    beat_out_t e;

    initial begin
        idle = mk_in(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        vecs[0] = mk_vec(mk_in(24'h800000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F), 1'b1, 1'b0, 1'b0, 1'b0, 1, 1);
        vecs[1] = mk_vec(mk_in(24'h000000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h10), 1'b0, 1'b0, 1'b1, 1'b1, 1, 1);
        vecs[2] = mk_vec(mk_in(24'h000000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h20), 1'b1, 1'b1, 1'b0, 1'b0, 2, 2);
        vecs[3] = mk_vec(mk_in(24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01), 1'b0, 1'b0, 1'b0, 1'b1, 2, 2);
        vecs[4] = mk_vec(mk_in(24'h123456, 1'b0, 1'b1, 1'b1, 1'b0, 8'h55), 1'b0, 1'b1, 1'b1, 1'b0, 2, 2);
        vecs[5] = mk_vec(mk_in(24'hABCDEF, 1'b1, 1'b1, 1'b1, 1'b0, 8'h66), 1'b0, 1'b1, 1'b1, 1'b0, 2, 2);
        vecs[6] = mk_vec(mk_in(24'hFFFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF), 1'b1, 1'b0, 1'b0, 1'b0, 3, 3);
        vecs[7] = mk_vec(mk_in(24'h000001, 1'b1, 1'b1, 1'b0, 1'b0, 8'h80), 1'b1, 1'b1, 1'b0, 1'b0, 4, 3);

        resetn = 1'b0; flush = 1'b0; clr_count = 1'b0; out_ready = 1'b1;
        drive(idle, 1'b0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.ov_count", 64'(ov_count), 64'd0);
        check("reset.adder", 64'(out_adder_out), 64'd0);
        check("reset.ex", 64'(out_current_ex), 64'd0);

        // Directed single beats through an empty stage, one-cycle latency each.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].in, 1'b1);
            tick();
            check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'd1);
            check_out($sformatf("vec%0d", i), vecs[i].exp);
            check($sformatf("vec%0d.ov_count", i), 64'(ov_count), 64'(vecs[i].cnt));
            check($sformatf("vec%0d.ov_count_c2", i), 64'(c2_ov_count), 64'(vecs[i].cnt2));
            drive(idle, 1'b0);
            tick();
            check($sformatf("vec%0d.drained", i), 64'(out_valid), 64'd0);
        end

        // Clear wins over a same-cycle overflow beat, then saturation at full rate.
        clr_count = 1'b1;
        drive(mk_in(24'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h90), 1'b1);
        tick();
        clr_count = 1'b0;
        check("clr.ov_count", 64'(ov_count), 64'd0);
        check("clr.ov_count_c2", 64'(c2_ov_count), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            drive(mk_in(24'h2, 1'b1, 1'b0, 1'b0, 1'b0, 8'(i)), 1'b1);
            tick();
            check($sformatf("thru%0d.out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("thru%0d.ex", i), 64'(out_current_ex), 64'(i));
        end
        drive(idle, 1'b0);
        tick();
        check("sat.ov_count", 64'(ov_count), 64'd5);
        check("sat.ov_count_c2", 64'(c2_ov_count), 64'd3);

        // Back-pressure: beat1 held, beat2 in skid, beat3 waits, then drain in order.
        out_ready = 1'b0;
        drive(mk_in(24'h31, 1'b0, 1'b0, 1'b0, 1'b0, 8'h31), 1'b1);
        tick();
        check("bp.b1.ex", 64'(out_current_ex), 64'h31);
        check("bp.b1.in_ready", 64'(in_ready), 64'd1);
        drive(mk_in(24'h32, 1'b0, 1'b0, 1'b0, 1'b0, 8'h32), 1'b1);
        tick();
        check("bp.full.ex", 64'(out_current_ex), 64'h31);
        check("bp.full.in_ready", 64'(in_ready), 64'd0);
        drive(mk_in(24'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33), 1'b1);
        tick();
        check("bp.hold.ex", 64'(out_current_ex), 64'h31);
        check("bp.hold.valid", 64'(out_valid), 64'd1);
        check("bp.hold.in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        check("bp.d2.ex", 64'(out_current_ex), 64'h32);
        check("bp.d2.in_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp.d3.ex", 64'(out_current_ex), 64'h33);
        drive(idle, 1'b0);
        tick();
        check("bp.empty", 64'(out_valid), 64'd0);

        // Flush with both entries full and a pending beat, then flush of a beat accepted into an empty stage.
        out_ready = 1'b0;
        drive(mk_in(24'h5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41), 1'b1);
        tick();
        drive(mk_in(24'h5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h42), 1'b1);
        tick();
        check("fl.pre.ov_count", 64'(ov_count), 64'd7);
        check("fl.pre.in_ready", 64'(in_ready), 64'd0);
        drive(mk_in(24'h5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43), 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(idle, 1'b0);
        check("fl.out_valid", 64'(out_valid), 64'd0);
        check("fl.in_ready", 64'(in_ready), 64'd1);
        check("fl.ov_count", 64'(ov_count), 64'd7);
        drive(mk_in(24'h5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h44), 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(idle, 1'b0);
        out_ready = 1'b1;
        check("fl2.out_valid", 64'(out_valid), 64'd0);
        check("fl2.ov_count", 64'(ov_count), 64'd7);
        tick();
        check("fl2.never", 64'(out_valid), 64'd0);
        drive(mk_in(24'h6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h45), 1'b1);
        tick();
        check("fl.after.ex", 64'(out_current_ex), 64'h45);
        drive(idle, 1'b0);
        tick();

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        drive(mk_in(24'h7, 1'b1, 1'b0, 1'b0, 1'b0, 8'h46), 1'b1);
        tick();
        check("rst.pre.valid", 64'(out_valid), 64'd1);
        check("rst.pre.ov_count", 64'(ov_count), 64'd8);
        #2;
        resetn = 1'b0;
        #1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.ov_count", 64'(ov_count), 64'd0);
        check("rst.ex", 64'(out_current_ex), 64'd0);
        drive(idle, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        tick();

        // Randomized traffic against the FIFO model.
        q.delete(); m_cnt = 0; m_cnt2 = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic v;
            logic ordy;
            logic fl;
            logic clr;
            check("rnd.out_valid", 64'(out_valid), 64'(q.size() > 0));
            check("rnd.in_ready", 64'(in_ready), 64'(q.size() < 2));
            if (q.size() > 0) begin
                e = q[0];
                check_out("rnd", e);
            end
            check("rnd.ov_count", 64'(ov_count), 64'(m_cnt));
            check("rnd.ov_count_c2", 64'(c2_ov_count), 64'(m_cnt2));
            v    = ($urandom_range(0, 99) < 70);
            ordy = ($urandom_range(0, 99) < 60);
            fl   = ($urandom_range(0, 99) < 3);
            clr  = ($urandom_range(0, 99) < 2);
            b.adder = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom);
            b.ov    = 1'($urandom);
            b.sign  = 1'($urandom);
            b.s1    = 1'($urandom);
            b.s2    = 1'($urandom);
            b.ex    = 8'($urandom);
            drive(b, v);
            out_ready = ordy;
            flush     = fl;
            clr_count = clr;
            model_step(v, b, ordy, fl, clr);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
